// File: rtl/icg_enable_ctrl.sv
// rtl/icg_enable_ctrl.sv - enable sequencer for a latch-based ICG with idle gating and four-phase wake
module icg_enable_ctrl #(
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic TE,
  input  logic BUSY,
  input  logic WAKE_REQ,
  output logic E,
  output logic WAKE_ACK,
  output logic GATED
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_GATED = 2'd2,
    S_WAKE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ack_nxt;

  // Next-state and counter selection; reset and test enable both force RUN.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (RST || TE) begin
      state_nxt = S_RUN;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_RUN: begin
          // A pending wake request also holds RUN, which keeps the ACK high.
          if (!BUSY && !WAKE_REQ) begin
            state_nxt = S_DRAIN;
            cnt_nxt   = IDLE_LOAD;
          end
        end
        S_DRAIN: begin
          // Activity is checked before the terminal count so it always wins over gating.
          if (BUSY || WAKE_REQ) begin
            state_nxt = S_RUN;
          end else if (cnt == '0) begin
            state_nxt = S_GATED;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        S_GATED: begin
          if (BUSY || WAKE_REQ) begin
            state_nxt = S_WAKE;
            cnt_nxt   = WAKE_LOAD;
          end
        end
        S_WAKE: begin
          // Settle window: inputs are ignored until the count expires.
          if (cnt == '0) begin
            state_nxt = S_RUN;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        default: begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end
      endcase
    end
    ack_nxt = (state_nxt == S_RUN) && WAKE_REQ && !TE && !RST;
  end

  // State, counter and registered outputs; E is derived from the next state so it is
  // a clean flop output, stable before the ICG latch opens in the low phase.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_RUN;
      cnt      <= '0;
      E        <= 1'b1;
      WAKE_ACK <= 1'b0;
      GATED    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      E        <= (state_nxt != S_GATED);
      WAKE_ACK <= ack_nxt;
      GATED    <= (state_nxt == S_GATED);
    end
  end

endmodule

// File: tb/tb_icg_enable_ctrl.sv
// tb/tb_icg_enable_ctrl.sv - scoreboard bench for icg_enable_ctrl
module tb_icg_enable_ctrl;

  logic CLK = 1'b0;
  logic RST, TE, BUSY, WAKE_REQ;
  logic E, WAKE_ACK, GATED;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic  chk;
    logic  e;
    logic  ack;
    logic  gated;
    string name;
  } exp_t;

  exp_t sb[$];

  icg_enable_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(2), .CNT_W(4)) dut (
    .CLK(CLK),
    .RST(RST),
    .TE(TE),
    .BUSY(BUSY),
    .WAKE_REQ(WAKE_REQ),
    .E(E),
    .WAKE_ACK(WAKE_ACK),
    .GATED(GATED)
  );

  always #5 CLK = ~CLK;

  // One cycle of stimulus: inputs are set on the falling edge and the outputs
  // expected after the following rising edge are queued.
  task automatic step(input logic rst, input logic te, input logic busy, input logic req,
                      input logic e, input logic ack, input logic gated, input string name);
    exp_t x;
    @(negedge CLK);
    RST = rst; TE = te; BUSY = busy; WAKE_REQ = req;
    x.chk = 1'b1; x.e = e; x.ack = ack; x.gated = gated; x.name = name;
    sb.push_back(x);
  endtask

  // Monitor: one queued expectation per rising edge, sampled 1 time unit later.
  always @(posedge CLK) begin
    #1;
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      if (x.chk) begin
        checks++;
        if ({E, WAKE_ACK, GATED} !== {x.e, x.ack, x.gated}) begin
          errors++;
          $display("FAIL %s: got E=%b ACK=%b GATED=%b, expected E=%b ACK=%b GATED=%b",
                   x.name, E, WAKE_ACK, GATED, x.e, x.ack, x.gated);
        end
      end
    end
  end

  initial begin
    RST = 1'b1; TE = 1'b0; BUSY = 1'b0; WAKE_REQ = 1'b0;
    //        rst te bsy req  E ack G
    step(1, 0, 0, 0,  1, 0, 0, "reset0");
    step(1, 0, 0, 0,  1, 0, 0, "reset1");
    // Idle gating: four DRAIN cycles after the RUN->DRAIN edge.
    step(0, 0, 0, 0,  1, 0, 0, "to_drain");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0, "drain_hold");
    step(0, 0, 0, 0,  0, 0, 1, "gate_idle");
    // BUSY wakes from GATED; inputs ignored during WAKE.
    step(0, 0, 1, 0,  1, 0, 0, "busy_wake");
    step(0, 0, 1, 0,  1, 0, 0, "wake_settle");
    step(0, 0, 1, 0,  1, 0, 0, "busy_run");
    // Abort drain at cnt==0, then a fresh full window.
    step(0, 0, 0, 0,  1, 0, 0, "drain2");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0, "drain2_hold");
    step(0, 0, 1, 0,  1, 0, 0, "abort_cnt0");
    step(0, 0, 0, 0,  1, 0, 0, "drain3");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0, "fresh_window");
    step(0, 0, 0, 0,  0, 0, 1, "gate_after_abort");
    // Four-phase wake handshake.
    step(0, 0, 0, 1,  1, 0, 0, "req_e_rise");
    step(0, 0, 0, 1,  1, 0, 0, "req_no_early_ack");
    step(0, 0, 0, 1,  1, 1, 0, "req_ack");
    step(0, 0, 0, 1,  1, 1, 0, "ack_hold0");
    step(0, 0, 0, 1,  1, 1, 0, "ack_hold1");
    step(0, 0, 0, 0,  1, 0, 0, "ack_fall");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0, "drain4_hold");
    step(0, 0, 0, 0,  0, 0, 1, "gate_after_req");
    // TE override, with a request held to show TE suppresses ACK.
    step(0, 1, 0, 0,  1, 0, 0, "te_ungate");
    for (int i = 0; i < 19; i++) step(0, 1, 0, 1, 1, 0, 0, "te_hold");
    step(0, 0, 0, 0,  1, 0, 0, "te_drop_drain");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0, "te_drain_hold");
    step(0, 0, 0, 0,  0, 0, 1, "gate_after_te");
    // Reset mid-WAKE with request still high.
    step(0, 0, 0, 1,  1, 0, 0, "wake_again");
    step(1, 0, 0, 1,  1, 0, 0, "rst_mid_wake");
    step(0, 0, 0, 1,  1, 1, 0, "run_req_ack");
    step(0, 0, 0, 0,  1, 0, 0, "run_req_drop");
    step(0, 0, 0, 1,  1, 1, 0, "drain_req_ack");
    step(0, 0, 1, 0,  1, 0, 0, "drain_req_drop");
    // Simultaneous BUSY and WAKE_REQ in GATED: one wake sequence.
    step(0, 0, 0, 0,  1, 0, 0, "drain5");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0, "drain5_hold");
    step(0, 0, 0, 0,  0, 0, 1, "gate5");
    step(0, 0, 1, 1,  1, 0, 0, "both_wake");
    step(0, 0, 1, 1,  1, 0, 0, "both_settle");
    step(0, 0, 1, 1,  1, 1, 0, "both_ack");
    step(0, 0, 1, 0,  1, 0, 0, "both_ack_fall");
    repeat (3) @(posedge CLK);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
